// File: rtl/user_reg_pkg.sv
// user_reg_pkg: shared widths, timeout data and FSM encodings for the user register master
package user_reg_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_DONE} acc_state_t;
  typedef enum logic [1:0] {INT_IDLE, INT_MSI, INT_ACK, INT_LOW} int_state_t;
endpackage

// File: rtl/user_intr_ctrl.sv
// user_intr_ctrl: turns a level interrupt into one MSI request and one user ack pulse
//   clk, rst_n        clock, synchronous active-low reset
//   intr_req          level interrupt request from user logic
//   intr_ack          one-cycle ack back to user logic
//   msi_req, msi_ack  MSI handshake with the PCIe core
module user_intr_ctrl
  import user_reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic intr_req,
  output logic intr_ack,
  output logic msi_req,
  input  logic msi_ack
);
  int_state_t state, state_d;
  always_ff @(posedge clk) state <= !rst_n ? INT_IDLE : state_d;
  always_comb begin
    state_d  = state;
    msi_req  = state == INT_MSI;
    intr_ack = state == INT_ACK;
    case (state)
      INT_IDLE: state_d = intr_req ? INT_MSI : INT_IDLE;
      INT_MSI:  state_d = msi_ack ? INT_ACK : INT_MSI;
      INT_ACK:  state_d = INT_LOW;
      INT_LOW:  state_d = intr_req ? INT_LOW : INT_IDLE;
      default:  state_d = INT_IDLE;
    endcase
  end
endmodule

// File: rtl/user_reg_master.sv
// user_reg_master: bridges host register commands to user-logic strobes, with read timeout and MSI forwarding
//   i_user_clk, i_rst        clock, synchronous active-low reset
//   i_host_*, o_host_*       host command side (write/read strobes, busy, read result)
//   o_user_*, i_user_*       user logic side (strobes, address, data, read ack)
//   i_intr_req, o_intr_ack   level interrupt handshake with user logic
//   o_msi_req, i_msi_ack     MSI handshake with the PCIe core
module user_reg_master
  import user_reg_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 256
) (
  input  logic              i_user_clk,
  input  logic              i_rst,
  input  logic              i_host_wr_req,
  input  logic              i_host_rd_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_busy,
  output logic [DATA_W-1:0] o_host_rd_data,
  output logic              o_host_rd_valid,
  output logic              o_host_rd_timeout,
  output logic              o_user_wr_req,
  output logic              o_user_rd_req,
  output logic [ADDR_W-1:0] o_user_addr,
  output logic [DATA_W-1:0] o_user_data,
  input  logic [DATA_W-1:0] i_user_data,
  input  logic              i_user_rd_ack,
  input  logic              i_intr_req,
  output logic              o_intr_ack,
  output logic              o_msi_req,
  input  logic              i_msi_ack
);
  acc_state_t  state, state_d;
  logic [15:0] cnt;
  logic        to_flag;
  logic        last;
  logic        idle;
  always_comb begin
    idle              = state == IDLE;
    last              = cnt == 16'(RD_TIMEOUT - 1);
    o_host_busy       = !idle;
    o_user_wr_req     = state == WR;
    o_host_rd_valid   = state == RD_DONE;
    o_host_rd_timeout = (state == RD_DONE) && to_flag;
    state_d           = state;
    case (state)
      IDLE:    state_d = i_host_wr_req ? WR : i_host_rd_req ? RD_WAIT : IDLE;
      WR:      state_d = IDLE;
      RD_WAIT: state_d = (i_user_rd_ack || last) ? RD_DONE : RD_WAIT;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_user_clk) begin
    if (!i_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      to_flag        <= 1'b0;
      o_user_rd_req  <= 1'b0;
      o_user_addr    <= '0;
      o_user_data    <= '0;
      o_host_rd_data <= '0;
    end else begin
      state         <= state_d;
      o_user_rd_req <= idle && i_host_rd_req && !i_host_wr_req;
      cnt           <= (state == RD_WAIT) ? cnt + 16'd1 : '0;
      if (idle && (i_host_wr_req || i_host_rd_req)) o_user_addr <= i_host_addr;
      if (idle && i_host_wr_req) o_user_data <= i_host_wdata;
      // an ack on the final counted cycle still beats the timeout
      if (state == RD_WAIT && i_user_rd_ack) begin
        o_host_rd_data <= i_user_data;
        to_flag        <= 1'b0;
      end else if (state == RD_WAIT && last) begin
        o_host_rd_data <= TIMEOUT_DATA;
        to_flag        <= 1'b1;
      end
    end
  end
  user_intr_ctrl u_intr (
    .clk      (i_user_clk),
    .rst_n    (i_rst),
    .intr_req (i_intr_req),
    .intr_ack (o_intr_ack),
    .msi_req  (o_msi_req),
    .msi_ack  (i_msi_ack)
  );
endmodule
